// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//
// Holds the receiver state encoding and the default bit period.
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

   // clk_50M cycles per bit for 115200 baud at 50 MHz
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//
// Ports:
//   clk_50M : clock, rising edge
//   rst     : synchronous active-high reset, forces both flops to 1
//   d       : asynchronous input
//   q       : synchronised output (two clk_50M cycles of latency)
module sync_2ff (
   input  logic clk_50M,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Reset to 1 so an idle-high line does not look like a start bit.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start bit, DATA_BITS data bits (LSB first),
// optional parity bit, STOP_BITS stop bits.
//
// Optional build macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits and the PARITY_ODD parameter (0 = even, 1 = odd).
//
// Parameters:
//   CLKS_PER_BIT : clk_50M cycles per bit (16..65535)
//   DATA_BITS    : data bits per frame (5..9)
//   STOP_BITS    : stop bits per frame (1 or 2)
// Ports:
//   clk_50M     : clock, rising edge
//   rst         : synchronous active-high reset
//   rx          : asynchronous serial line, idle high
//   rx_msg      : last received word
//   rx_complete : one-cycle pulse in the last cycle of the final stop bit
//   frame_err   : a stop bit was sampled low, valid with rx_complete
//   parity_err  : parity mismatch, valid with rx_complete (0 without parity)
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
   ,
   parameter int PARITY_ODD   = 0
`endif
) (
   input  logic                 clk_50M,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_msg,
   output logic                 rx_complete,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int BIT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   logic                 rxs;
   uart_state_e          state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [BIT_W-1:0]     bit_idx, bit_idx_n;
   logic                 stop_idx, stop_idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 ferr_pend, ferr_pend_n;
   logic [DATA_BITS-1:0] rx_msg_n;
   logic                 rx_complete_n;
   logic                 frame_err_n;
   logic                 mid_bit, end_bit;

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic par_pend, par_pend_n;
   logic parity_err_n;
`endif

   sync_2ff u_sync (
      .clk_50M (clk_50M),
      .rst     (rst),
      .d       (rx),
      .q       (rxs)
   );

   assign mid_bit = (cnt == CNT_HALF);
   assign end_bit = (cnt == CNT_FULL);

   // Next-state and datapath. cnt runs 1..CLKS_PER_BIT within each bit and
   // is reloaded with 1 at the bit boundary, so it never wraps.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      bit_idx_n     = bit_idx;
      stop_idx_n    = stop_idx;
      shreg_n       = shreg;
      ferr_pend_n   = ferr_pend;
      rx_msg_n      = rx_msg;
      rx_complete_n = 1'b0;
      frame_err_n   = frame_err;
`ifdef UART_RX_PARITY_EN
      par_pend_n    = par_pend;
      parity_err_n  = parity_err;
`endif

      case (state)
         IDLE: begin
            if (!rxs) begin
               state_n     = START;
               cnt_n       = CNT_ONE;
               ferr_pend_n = 1'b0;
`ifdef UART_RX_PARITY_EN
               par_pend_n  = 1'b0;
`endif
            end
         end

         // A start bit that is high again at mid-bit was a glitch.
         START: begin
            if (mid_bit && rxs) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (end_bit) begin
               state_n   = DATA;
               cnt_n     = CNT_ONE;
               bit_idx_n = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         DATA: begin
            if (mid_bit) begin
               shreg_n = {rxs, shreg[DATA_BITS-1:1]};
            end
            if (end_bit) begin
               cnt_n = CNT_ONE;
               if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
                  stop_idx_n = 1'b0;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (mid_bit) begin
               par_pend_n = ((^shreg) ^ rxs) != PAR_ODD;
            end
            if (end_bit) begin
               state_n    = STOP;
               cnt_n      = CNT_ONE;
               stop_idx_n = 1'b0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
`endif

         // Outputs are registered one cycle early so rx_complete is seen in
         // the final cycle of the last stop bit. If the line is already low
         // at that point after a clean stop, it is the next start bit
         // (zero-gap frames); after a bad stop it is treated as a break.
         STOP: begin
            if (mid_bit && !rxs) begin
               ferr_pend_n = 1'b1;
            end
            if ((cnt == CNT_LAST) && (stop_idx == STOP_LAST)) begin
               rx_complete_n = 1'b1;
               rx_msg_n      = shreg;
               frame_err_n   = ferr_pend;
`ifdef UART_RX_PARITY_EN
               parity_err_n  = par_pend;
`endif
            end
            if (end_bit) begin
               if (stop_idx != STOP_LAST) begin
                  stop_idx_n = stop_idx + 1'b1;
                  cnt_n      = CNT_ONE;
               end else if (rxs) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else if (!ferr_pend) begin
                  state_n     = START;
                  cnt_n       = CNT_ONE;
                  ferr_pend_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                  par_pend_n  = 1'b0;
`endif
               end else begin
                  state_n = WAIT_IDLE;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end

         WAIT_IDLE: begin
            if (rxs) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         shreg       <= '0;
         ferr_pend   <= 1'b0;
         rx_msg      <= '0;
         rx_complete <= 1'b0;
         frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pend    <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_idx     <= bit_idx_n;
         stop_idx    <= stop_idx_n;
         shreg       <= shreg_n;
         ferr_pend   <= ferr_pend_n;
         rx_msg      <= rx_msg_n;
         rx_complete <= rx_complete_n;
         frame_err   <= frame_err_n;
`ifdef UART_RX_PARITY_EN
         par_pend    <= par_pend_n;
         parity_err  <= parity_err_n;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: default instance (434 clk/bit, 8N1) and a small
// instance (16 clk/bit, 7 data bits, 2 stop bits). Frames are pushed into a
// per-instance expected queue when sent; monitors pop and compare on every
// rx_complete pulse, including the cycle at which it appears.
module tb_uart_rx_cfg;

`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int CA = 434;
   localparam int CB = 16;

   typedef struct {
      logic [8:0] msg;
      logic       ferr;
      logic       perr;
      int         t;
   } exp_t;

   logic       clk_50M = 1'b0;
   logic       rst;
   logic       rx_a, rx_b;
   logic [7:0] rx_msg_a;
   logic [6:0] rx_msg_b;
   logic       rx_complete_a, rx_complete_b;
   logic       frame_err_a, frame_err_b;
   logic       parity_err_a, parity_err_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   uart_rx_cfg u_dut_a (
      .clk_50M     (clk_50M),
      .rst         (rst),
      .rx          (rx_a),
      .rx_msg      (rx_msg_a),
      .rx_complete (rx_complete_a),
      .frame_err   (frame_err_a),
      .parity_err  (parity_err_a)
   );

   uart_rx_cfg #(
      .CLKS_PER_BIT (CB),
      .DATA_BITS    (7),
      .STOP_BITS    (2)
   ) u_dut_b (
      .clk_50M     (clk_50M),
      .rst         (rst),
      .rx          (rx_b),
      .rx_msg      (rx_msg_b),
      .rx_complete (rx_complete_b),
      .frame_err   (frame_err_b),
      .parity_err  (parity_err_b)
   );

   always #10 clk_50M = ~clk_50M;

   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic send_bit(input bit sel_b, input logic v, input int clks);
      if (sel_b) rx_b = v;
      else       rx_a = v;
      idle(clks);
   endtask

   function automatic logic calc_par(input logic [8:0] d, input int n);
      logic p = 1'b0;
      for (int i = 0; i < n; i++) p ^= d[i];
      return p;
   endfunction

   // Sends one frame; must be called one delta past a rising edge. The
   // expected completion is two synchroniser cycles plus one frame length
   // after the edge at which the start bit was driven.
   task automatic apply_stimulus(input bit sel_b, input logic [8:0] data, input int nbits,
                                 input int nstop, input int clks, input logic par_bit,
                                 input logic stop_val, input bit push,
                                 input logic exp_ferr, input logic exp_perr);
      exp_t e;
      if (push) begin
         e.msg  = data & ((9'd1 << nbits) - 9'd1);
         e.ferr = exp_ferr;
         e.perr = exp_perr;
         e.t    = cyc + 2 + clks * (1 + nbits + P + nstop);
         if (sel_b) q_b.push_back(e);
         else       q_a.push_back(e);
      end
      send_bit(sel_b, 1'b0, clks);
      for (int i = 0; i < nbits; i++) send_bit(sel_b, data[i], clks);
      if (P != 0) send_bit(sel_b, par_bit, clks);
      for (int i = 0; i < nstop; i++) send_bit(sel_b, stop_val, clks);
   endtask

   task automatic wait_drain(input bit sel_b, input int budget);
      int n = 0;
      while (((sel_b ? q_b.size() : q_a.size()) != 0) && (n < budget)) begin
         idle(1);
         n++;
      end
      if ((sel_b ? q_b.size() : q_a.size()) != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_%s: %0d frames still pending, expected 0",
                  sel_b ? "b" : "a", sel_b ? q_b.size() : q_a.size());
         if (sel_b) q_b.delete();
         else       q_a.delete();
      end
   endtask

   always @(negedge clk_50M) begin
      if (rx_complete_a === 1'b1) begin
         exp_t e;
         if (q_a.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL a_unexpected: rx_complete at cycle %0d msg=%0h, expected no pulse", cyc, rx_msg_a);
         end else begin
            e = q_a.pop_front();
            check_output("a_msg",  32'(rx_msg_a),     32'(e.msg));
            check_output("a_ferr", 32'(frame_err_a),  32'(e.ferr));
            check_output("a_perr", 32'(parity_err_a), 32'(e.perr));
            check_output("a_time", cyc,               e.t);
         end
      end
   end

   always @(negedge clk_50M) begin
      if (rx_complete_b === 1'b1) begin
         exp_t e;
         if (q_b.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL b_unexpected: rx_complete at cycle %0d msg=%0h, expected no pulse", cyc, rx_msg_b);
         end else begin
            e = q_b.pop_front();
            check_output("b_msg",  32'(rx_msg_b),     32'(e.msg));
            check_output("b_ferr", 32'(frame_err_b),  32'(e.ferr));
            check_output("b_perr", 32'(parity_err_b), 32'(e.perr));
            check_output("b_time", cyc,               e.t);
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected to have finished", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst  = 1'b1;
      rx_a = 1'b1;
      rx_b = 1'b1;
      idle(5);
      check_output("rst_msg_a",  32'(rx_msg_a),      32'h0);
      check_output("rst_cmp_a",  32'(rx_complete_a), 32'h0);
      check_output("rst_ferr_a", 32'(frame_err_a),   32'h0);
      check_output("rst_perr_a", 32'(parity_err_a),  32'h0);
      check_output("rst_msg_b",  32'(rx_msg_b),      32'h0);
      rst = 1'b0;
      idle(10);

      // 0xA5, clean: completes 4340 cycles after start detect (4774 with parity)
      apply_stimulus(1'b0, 9'h0A5, 8, 1, CA, calc_par(9'h0A5, 8), 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain(1'b0, 20);
      idle(50);

      // False start: 100 low cycles, nothing received, word unchanged
      rx_a = 1'b0;
      idle(100);
      rx_a = 1'b1;
      idle(5000);
      check_output("false_start_msg", 32'(rx_msg_a), 32'hA5);

      // 0x3C with a low stop bit, then a 2000-cycle break
      apply_stimulus(1'b0, 9'h03C, 8, 1, CA, calc_par(9'h03C, 8), 1'b0, 1'b1, 1'b1, 1'b0);
      wait_drain(1'b0, 20);
      idle(2000);
      rx_a = 1'b1;
      idle(5000);
      check_output("break_msg_hold",  32'(rx_msg_a),    32'h3C);
      check_output("break_ferr_hold", 32'(frame_err_a), 32'h1);

      // Back-to-back 0x00 then 0xFF with no idle gap
      apply_stimulus(1'b0, 9'h000, 8, 1, CA, calc_par(9'h000, 8), 1'b1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 9'h0FF, 8, 1, CA, calc_par(9'h0FF, 8), 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain(1'b0, 20);
      idle(20);

      // Small instance: 7 data bits, 2 stop bits, 16 clk/bit -> 160 cycles
      apply_stimulus(1'b1, 9'h055, 7, 2, CB, calc_par(9'h055, 7), 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain(1'b1, 20);
      idle(20);

      // Reset pulse during data bit 4 of 0x5A aborts the frame
      send_bit(1'b0, 1'b0, CA);
      send_bit(1'b0, 1'b0, CA);
      send_bit(1'b0, 1'b1, CA);
      send_bit(1'b0, 1'b0, CA);
      send_bit(1'b0, 1'b1, CA);
      rx_a = 1'b1;
      idle(CA / 2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_output("midrst_msg_a",  32'(rx_msg_a),      32'h0);
      check_output("midrst_cmp_a",  32'(rx_complete_a), 32'h0);
      check_output("midrst_ferr_a", 32'(frame_err_a),   32'h0);
      check_output("midrst_perr_a", 32'(parity_err_a),  32'h0);
      check_output("midrst_msg_b",  32'(rx_msg_b),      32'h0);
      idle(3 * CA);

      apply_stimulus(1'b0, 9'h081, 8, 1, CA, calc_par(9'h081, 8), 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain(1'b0, 20);
      idle(20);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit must be 1
      apply_stimulus(1'b0, 9'h007, 8, 1, CA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_drain(1'b0, 20);
      idle(20);
      apply_stimulus(1'b0, 9'h007, 8, 1, CA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain(1'b0, 20);
      idle(20);
`endif

      idle(100);
      check_output("final_q_a", 32'(q_a.size()), 32'h0);
      check_output("final_q_b", 32'(q_b.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
